// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad-to-BCD timer entry path.
package keypad_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned KEYS    = 10;
   localparam int unsigned CNT_W   = 8;

   localparam logic [DIGIT_W-1:0] MAX_DEZENA = 4'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } key_state_t;

endpackage

// File: rtl/key_onehot_to_bcd.sv
// Classifies a 10-bit key pattern: BCD index of the set bit and a flag that
// exactly one bit is set.
module key_onehot_to_bcd
   import keypad_pkg::*;
(
   input  logic [KEYS-1:0]    pattern,
   output logic [DIGIT_W-1:0] code,
   output logic               onehot
);

   logic [3:0] ones;

   always_comb begin
      code = '0;
      ones = '0;
      for (int i = 0; i < int'(KEYS); i++) begin
         if (pattern[i]) begin
            code = DIGIT_W'(i);
            ones = ones + 4'd1;
         end
      end
      onehot = (ones == 4'd1);
   end

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Synchronises and debounces the one-hot keypad and left-shifts accepted
// digits into the three BCD timer digits.
module keypad_bcd_encoder
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEYS-1:0]    Keypad,
   input  logic               Enable,
   input  logic               Clear,
   output logic [DIGIT_W-1:0] Minutos,
   output logic [DIGIT_W-1:0] DezenaSeg,
   output logic [DIGIT_W-1:0] UnidadeSeg,
   output logic               KeyStrobe,
   output logic               KeyReject,
   output logic               Valid
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [KEYS-1:0]    sync1_q, sync1_d;
   logic [KEYS-1:0]    sync2_q, sync2_d;
   logic [KEYS-1:0]    pat_q, pat_d;
   key_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIGIT_W-1:0] min_q, min_d;
   logic [DIGIT_W-1:0] dez_q, dez_d;
   logic [DIGIT_W-1:0] uni_q, uni_d;
   logic               strobe_q, strobe_d;
   logic               reject_q, reject_d;

   logic [DIGIT_W-1:0] key_code;
   logic               key_onehot;
   logic               accept;

   key_onehot_to_bcd u_classify (
      .pattern (sync2_q),
      .code    (key_code),
      .onehot  (key_onehot)
   );

   // Debounce FSM, accept action and digit shift register.
   always_comb begin
      sync1_d  = Keypad;
      sync2_d  = sync1_q;
      pat_d    = pat_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      min_d    = min_q;
      dez_d    = dez_q;
      uni_d    = uni_q;
      strobe_d = 1'b0;
      reject_d = 1'b0;
      accept   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (key_onehot) begin
               pat_d   = sync2_q;
               state_d = ST_DEBOUNCE;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (sync2_q != pat_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HELD;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (sync2_q == '0) begin
               state_d = ST_RELEASE;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (sync2_q != '0) begin
               state_d = ST_HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Refusing a shift while units > 5 keeps the tens-of-seconds digit legal.
      if (accept && Enable) begin
         if (uni_q > MAX_DEZENA) begin
            reject_d = 1'b1;
         end else begin
            strobe_d = 1'b1;
            min_d    = dez_q;
            dez_d    = uni_q;
            uni_d    = key_code;
         end
      end

      if (Clear) begin
         min_d = '0;
         dez_d = '0;
         uni_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         pat_q    <= '0;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         min_q    <= '0;
         dez_q    <= '0;
         uni_q    <= '0;
         strobe_q <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         pat_q    <= pat_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         min_q    <= min_d;
         dez_q    <= dez_d;
         uni_q    <= uni_d;
         strobe_q <= strobe_d;
         reject_q <= reject_d;
      end
   end

   assign Minutos    = min_q;
   assign DezenaSeg  = dez_q;
   assign UnidadeSeg = uni_q;
   assign KeyStrobe  = strobe_q;
   assign KeyReject  = reject_q;
   assign Valid      = |{min_q, dez_q, uni_q};

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Bench for keypad_bcd_encoder: run-length reference model checked every
// cycle, directed scenarios with literal expectations, then random presses.
module tb_keypad_bcd_encoder;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] Keypad;
   logic       Enable;
   logic       Clear;
   logic [3:0] Minutos, DezenaSeg, UnidadeSeg;
   logic       KeyStrobe, KeyReject, Valid;

   int errors = 0;
   int checks = 0;

   keypad_bcd_encoder #(.DEBOUNCE_CYCLES(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Keypad     (Keypad),
      .Enable     (Enable),
      .Clear      (Clear),
      .Minutos    (Minutos),
      .DezenaSeg  (DezenaSeg),
      .UnidadeSeg (UnidadeSeg),
      .KeyStrobe  (KeyStrobe),
      .KeyReject  (KeyReject),
      .Valid      (Valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a key is taken after D identical one-hot samples of the
   // synchronised keypad, and re-armed only after D consecutive empty samples.
   int         m_min, m_dez, m_uni;
   bit         m_stb, m_rej;
   logic [9:0] m_s1, m_s2, cand;
   int         run, zrun;
   bit         armed;

   function automatic int key_index(input logic [9:0] v);
      for (int i = 0; i < 10; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_min = 0; m_dez = 0; m_uni = 0; m_stb = 0; m_rej = 0;
         m_s1 = '0; m_s2 = '0; cand = '0; run = 0; zrun = 0; armed = 1;
      end else begin
         logic [9:0] x;
         bit         taken;
         x = m_s2;
         m_s2 = m_s1;
         m_s1 = Keypad;
         m_stb = 0; m_rej = 0; taken = 0;
         if (armed) begin
            if (run == 0) begin
               if ($countones(x) == 1) begin cand = x; run = 1; end
            end else if (x == cand) begin
               run++;
               if (run == D) begin taken = 1; armed = 0; zrun = 0; end
            end else begin
               run = 0;
            end
         end else begin
            if (x == 0) begin
               zrun++;
               if (zrun == D) begin armed = 1; run = 0; end
            end else begin
               zrun = 0;
            end
         end
         if (taken && Enable) begin
            if (m_uni > 5) m_rej = 1;
            else begin
               m_stb = 1; m_min = m_dez; m_dez = m_uni; m_uni = key_index(cand);
            end
         end
         if (Clear) begin m_min = 0; m_dez = 0; m_uni = 0; end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #1;
      check("cycle_outputs",
            {18'd0, Minutos, DezenaSeg, UnidadeSeg, KeyStrobe, KeyReject, Valid},
            {18'd0, 4'(m_min), 4'(m_dez), 4'(m_uni), m_stb, m_rej,
             1'((m_min | m_dez | m_uni) != 0)});
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic hold_keys(input logic [9:0] pat, input int n,
                            output int s, output int r, output int first);
      @(negedge clk);
      Keypad = pat;
      s = 0; r = 0; first = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         if (KeyStrobe) begin s++; if (first == 0) first = i; end
         if (KeyReject) r++;
      end
   endtask

   task automatic press(input int k, output int s, output int r);
      int f, s2, r2;
      hold_keys(10'(1) << k, 10, s, r, f);
      hold_keys('0, 8, s2, r2, f);
   endtask

   task automatic pulse_clear();
      @(negedge clk); Clear = 1'b1;
      @(negedge clk); Clear = 1'b0;
   endtask

   task automatic check_digits(input string name, input logic [11:0] exp);
      check(name, {20'd0, Minutos, DezenaSeg, UnidadeSeg}, {20'd0, exp});
   endtask

   int s, r, f;
   int keys2[6] = '{1, 2, 3, 4, 5, 9};
   logic [11:0] exp2[6] = '{12'h001, 12'h012, 12'h123, 12'h234, 12'h345, 12'h459};

   initial begin
      rst_n = 1'b0; Keypad = '0; Enable = 1'b1; Clear = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {26'd0, Minutos, DezenaSeg, UnidadeSeg, KeyStrobe, KeyReject, Valid} >> 0, 32'd0);
      rst_n = 1'b1;

      // Single press of key 3.
      hold_keys(10'(1) << 3, 12, s, r, f);
      check("t1_strobe_count", 32'(s), 32'd1);
      check("t1_strobe_edge", 32'(f), 32'(2 + D));
      hold_keys('0, 8, s, r, f);
      check_digits("t1_digits", 12'h003);
      check("t1_valid", {31'd0, Valid}, 32'd1);

      // Shift sequence, then refusal with units = 9.
      pulse_clear();
      for (int i = 0; i < 6; i++) begin
         press(keys2[i], s, r);
         check_digits($sformatf("t2_digits_key%0d", keys2[i]), exp2[i]);
      end
      press(7, s, r);
      check("t2_reject_count", 32'(r), 32'd1);
      check("t2_reject_no_strobe", 32'(s), 32'd0);
      check_digits("t2_digits_after_reject", 12'h459);

      // Bouncing key 5, then a stable hold.
      pulse_clear();
      s = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         Keypad = ((i / 2) % 2 == 0) ? 10'(1) << 5 : 10'd0;
         @(posedge clk); #1;
         if (KeyStrobe) s++;
      end
      check("t3_bounce_no_strobe", 32'(s), 32'd0);
      hold_keys(10'(1) << 5, 10, s, r, f);
      check("t3_hold_strobe", 32'(s), 32'd1);
      check("t3_units", {28'd0, UnidadeSeg}, 32'd5);
      hold_keys('0, 8, s, r, f);

      // Two keys at once, then a new key while held.
      hold_keys(10'b0000000110, 20, s, r, f);
      check("t4_multi_no_strobe", 32'(s), 32'd0);
      check("t4_multi_no_reject", 32'(r), 32'd0);
      hold_keys('0, 8, s, r, f);
      pulse_clear();
      hold_keys(10'(1) << 1, 10, s, r, f);
      hold_keys(10'(1) << 8, 10, s, r, f);
      check("t4_held_new_key_ignored", 32'(s + r), 32'd0);
      hold_keys('0, 8, s, r, f);
      check_digits("t4_digits", 12'h001);

      // Clear on the strobe edge, then entry disabled.
      @(negedge clk); Keypad = 10'(1) << 4;
      repeat (2 + D - 1) @(posedge clk);
      @(negedge clk); Clear = 1'b1;
      @(posedge clk); #1;
      check("t5_strobe_with_clear", {31'd0, KeyStrobe}, 32'd1);
      check_digits("t5_cleared", 12'h000);
      @(negedge clk); Clear = 1'b0;
      hold_keys('0, 8, s, r, f);
      press(7, s, r);
      Enable = 1'b0;
      press(6, s, r);
      check("t5_disabled_no_pulse", 32'(s + r), 32'd0);
      check_digits("t5_disabled_digits", 12'h007);
      Enable = 1'b1;

      // Asynchronous reset in the middle of a debounce.
      @(negedge clk); Keypad = 10'(1) << 2;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("t6_async_reset",
               {26'd0, Minutos, DezenaSeg, UnidadeSeg, KeyStrobe, KeyReject, Valid}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      s = 0; f = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (KeyStrobe) begin s++; if (f == 0) f = i; end
      end
      check("t6_strobe_count", 32'(s), 32'd1);
      check("t6_strobe_edge", 32'(f), 32'(2 + D));
      hold_keys('0, 8, s, r, f);
      check_digits("t6_digits", 12'h002);

      // Random presses, bounces, multi-key patterns, Enable and Clear.
      for (int it = 0; it < 300; it++) begin
         logic [9:0] pat;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 7)       pat = 10'(1) << $urandom_range(0, 9);
         else if (sel == 7) pat = '0;
         else               pat = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
         Enable = ($urandom_range(0, 9) != 0);
         Clear  = ($urandom_range(0, 29) == 0);
         hold_keys(pat, $urandom_range(1, 14), s, r, f);
         Clear = 1'b0;
      end
      hold_keys('0, 10, s, r, f);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_bcd_encoder.md
# keypad_bcd_encoder

Front-end of the microwave-timer panel, opposite end of the BCD-to-7-segment display path. It synchronises and debounces a 10-key one-hot keypad, encodes the accepted key to BCD, and shifts it into the three BCD timer digits (minutes, tens of seconds, units of seconds) that feed the display decoder and the countdown logic. Entry is left-shift, so the newest digit enters at the units position.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a press or a release. Legal range is 2..255.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Keypad` in 10: raw keys, asynchronous to `clk`. `Keypad[i]` high means digit i is pressed.
- `Enable` in 1: entry allowed. Low while the timer is running.
- `Clear` in 1: synchronous clear of all three digits.
- `Minutos` out 4: BCD minutes digit, 0..9.
- `DezenaSeg` out 4: BCD tens-of-seconds digit, 0..5.
- `UnidadeSeg` out 4: BCD units-of-seconds digit, 0..9.
- `KeyStrobe` out 1: one-cycle pulse when a digit is shifted in.
- `KeyReject` out 1: one-cycle pulse when an accepted key is refused.
- `Valid` out 1: high when any digit is nonzero.

## Operation
- **Synchroniser:** two flops on `Keypad` produce `s2`.
- **Pattern classification:** `s2` is a valid pattern only if exactly one bit is set. Zero bits or multiple bits count as "no key".
- **FSM states:** IDLE, DEBOUNCE, HELD, RELEASE. A counter `cnt` is 8 bits wide.
- **IDLE:**
  - Valid pattern P: latch P, go to DEBOUNCE, set `cnt` = 1.
- **DEBOUNCE:**
  - `s2` differs from P: return to IDLE.
  - `s2` equals P and `cnt` == `DEBOUNCE_CYCLES`-1: go to HELD and run the accept action.
  - Otherwise increment `cnt`.
- **Accept action** (registered, same edge as the entry into HELD):
  - `Enable` = 0: no strobe, no reject, digits hold.
  - `Enable` = 1 and `UnidadeSeg` > 5: `KeyReject` = 1 and digits hold, so `DezenaSeg` never exceeds 5.
  - Otherwise: `KeyStrobe` = 1, `Minutos` ← `DezenaSeg`, `DezenaSeg` ← `UnidadeSeg`, `UnidadeSeg` ← index of P. The old `Minutos` is discarded.
- **HELD:**
  - Any nonzero `s2`, including a different key: stay in HELD. A release is required between keys.
  - `s2` == 0: go to RELEASE, set `cnt` = 1.
- **RELEASE:**
  - `s2` nonzero: return to HELD.
  - `cnt` == `DEBOUNCE_CYCLES`-1: go to IDLE.
  - Otherwise increment `cnt`.
- **Clear:** when `Clear` = 1 at an edge, all digits become 0. Clear has priority over a same-edge shift.
  - `KeyStrobe` still pulses if the accept condition held.
  - The FSM is unaffected.
- **Valid:** combinational OR of the digits.

## Timing
- **Reset:** the following clear immediately, regardless of clock:
  - digits: 0
  - `KeyStrobe`, `KeyReject`, `Valid`: 0
  - FSM state: IDLE
  - `cnt`: 0
  - synchroniser flops: 0
- **Press latency:** `Keypad` stable from before edge 0 gives `s2` = P after edge 2 and DEBOUNCE after edge 3. The accept action happens at edge 2+`DEBOUNCE_CYCLES`, with `KeyStrobe` high for exactly that one cycle.
- **Release latency:** a release is accepted `DEBOUNCE_CYCLES`+2 edges after the `Keypad` release.
- **Minimum key period:** about 2·(`DEBOUNCE_CYCLES`+2) cycles.
- **Pulse exclusivity:** `KeyStrobe` and `KeyReject` are never high together. Each is at most one cycle per press.
- **Reset mid-operation:** any partial debounce is lost. A key still held after reset is treated as a new press, needing the full `DEBOUNCE_CYCLES` again.

## Structure
- Package `keypad_pkg`:
  - FSM state enum `key_state_t`
  - `DIGIT_W` = 4
  - `MAX_DEZENA` = 4'd5
  - `KEYS` = 10
- Sub-module `key_onehot_to_bcd` (combinational): input 10-bit pattern; outputs 4-bit code and a one-hot valid flag. Reused by a later keypad-to-display self-test.
- Top module holds the synchroniser, FSM, counter and digit registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
1. Press key 3 stable for 12 cycles, then release → single `KeyStrobe` in the cycle after edge 6; digits become 0/0/3; `Valid` = 1.
2. Keys 1, 2, 3, 4, 5, 9, each with a full release → 0:01, 0:12, 1:23, 2:34, 3:45, 4:59. Then key 7 → `KeyReject` pulse; digits stay 4:59.
3. Key 5 toggling every 2 cycles for 16 cycles → no strobe. Then held 10 cycles → exactly one strobe; `UnidadeSeg` = 5.
4. `Keypad` = 10'b0000000110 (two keys) held 20 cycles → no strobe, no reject. Key 8 pressed during HELD without release → ignored.
5. `Clear` pulsed on the strobe edge → digits 0:00 with `KeyStrobe` = 1. With `Enable` = 0, pressing key 6 → no strobe and digits unchanged.
6. `rst_n` pulsed low while in DEBOUNCE with key 2 held → outputs 0 immediately. After reset, with key 2 still held, exactly one strobe occurs 2+`DEBOUNCE_CYCLES` edges later.
